// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART receive path.
//  UART_DATA_BITS : data bits per frame (8N1)
//  OVERSAMPLE     : sample ticks per bit period
//  rx_state_e     : receiver FSM state encoding
//  tick_div()     : system clocks per sample tick, truncated
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned OVERSAMPLE     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: circular buffer with wrapping pointers and an occupancy
// counter. The head entry is held in a register so rd_data is glitch-free and
// changes on the same edge the read pointer moves.
//  clk, rst  : clock, asynchronous active-high reset
//  wr_en     : write request (dropped when full unless a pop happens too)
//  wr_data   : byte to write
//  rd_en     : pop request (ignored when empty)
//  rd_data   : registered head entry
//  count     : occupancy 0..DEPTH
//  full      : count == DEPTH
//  empty     : count == 0
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             do_wr;
  logic             do_rd;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_rd      = rd_en & ~empty;
  // A simultaneous pop frees a slot, so a write into a full FIFO succeeds.
  assign do_wr      = wr_en & (~full | do_rd);
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (do_wr && !do_rd) begin
        count <= count + 1'b1;
      end else if (!do_wr && do_rd) begin
        count <= count - 1'b1;
      end
      // Head register: next stored entry after a pop, or the incoming byte
      // when it becomes the new head (FIFO empty, or last entry popped).
      if (do_rd && (count != (AW+1)'(1))) begin
        rd_data <= mem[rd_ptr_nxt];
      end else if (do_wr && (empty || do_rd)) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver, 8N1, LSB first, with a receive FIFO.
//  clk         : system clock, rising edge
//  rst         : asynchronous reset, active-high
//  rx          : serial input, idle high, asynchronous to clk
//  rx_data     : FIFO head byte, valid while rx_valid=1
//  rx_valid    : FIFO non-empty
//  rx_ready    : consumer pop (pop on an edge with rx_valid & rx_ready)
//  rx_done     : 1-clk pulse when a good byte enters the FIFO
//  frame_err   : 1-clk pulse when the stop bit is sampled low (byte dropped)
//  overrun     : sticky, good byte arrived with the FIFO full (byte dropped)
//  fifo_count  : FIFO occupancy
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_done,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, BAUD);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  rx_state_e state, state_nxt;

  logic                      rx_meta, rx_s, rx_prev;
  logic [TW-1:0]             tick_cnt;
  logic                      tick;
  logic [3:0]                s;
  logic [2:0]                bit_idx;
  logic                      v7, v8, bit_val;
  logic                      maj3;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      s_clr;
  logic                      stop_ok;
  logic                      ferr_set;
  logic                      fifo_full, fifo_empty;
  logic                      fifo_pop;
  logic                      full_blocked;
  logic                      start_edge;

  // rx_prev is an edge-detect stage behind the two-flop synchroniser. Because
  // a falling edge needs rx_s to have been high first, IDLE naturally waits
  // for the line to return high after a frame error or break.
  assign start_edge   = rx_prev & ~rx_s;
  assign tick         = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
  assign maj3         = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
  assign fifo_pop     = rx_valid & rx_ready;
  assign full_blocked = fifo_full & ~fifo_pop;
  assign rx_valid     = ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_clr     = 1'b0;
    stop_ok   = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          s_clr     = 1'b1;
        end
      end
      START: begin
        if (tick && (s == 4'd7)) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            s_clr     = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick && (s == 4'd15) && (bit_idx == 3'(UART_DATA_BITS - 1))) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Decide at the third vote and leave early so the next start edge
        // can be caught before the nominal end of the stop bit.
        if (tick && (s == 4'd9)) begin
          state_nxt = IDLE;
          stop_ok   = maj3;
          ferr_set  = ~maj3;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      tick_cnt  <= '0;
      s         <= '0;
      bit_idx   <= '0;
      v7        <= 1'b0;
      v8        <= 1'b0;
      bit_val   <= 1'b0;
      shreg     <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;

      if ((state == IDLE) || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (s_clr) begin
        s <= '0;
      end else if (tick) begin
        s <= s + 1'b1;
      end

      if (s_clr) begin
        bit_idx <= '0;
      end else if ((state == DATA) && tick && (s == 4'd15)) begin
        bit_idx <= bit_idx + 1'b1;
      end

      if (tick) begin
        case (s)
          4'd7:    v7      <= rx_s;
          4'd8:    v8      <= rx_s;
          4'd9:    bit_val <= maj3;
          default: ;
        endcase
      end

      if ((state == DATA) && tick && (s == 4'd15)) begin
        shreg <= {bit_val, shreg[UART_DATA_BITS-1:1]};
      end

      rx_done   <= stop_ok & ~full_blocked;
      frame_err <= ferr_set;
      if (stop_ok && full_blocked) begin
        overrun <= 1'b1;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (stop_ok),
    .wr_data (shreg),
    .rd_en   (fifo_pop),
    .rd_data (rx_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_os16.sv
module tb_uart_rx_os16;

  localparam int unsigned DEPTH     = 4;
  localparam int          FAST_BCLK = 64;   // 16 * (50e6 / (781250*16))
  localparam int          SLOW_BCLK = 434;  // 50e6 / 115200

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_done, frame_err, overrun;
  logic [2:0] fifo_count;

  logic       rx_slow = 1'b1;
  logic [7:0] slow_rx_data;
  logic       slow_rx_valid, slow_rx_done, slow_frame_err, slow_overrun;
  logic [2:0] slow_fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bytes the receiver should hold, and cumulative event counts.
  logic [7:0] exp_q[$];
  int         exp_done = 0;
  int         exp_ferr = 0;
  logic       exp_ovr  = 1'b0;

  int         done_cnt = 0, ferr_cnt = 0, slow_done_cnt = 0, slow_ferr_cnt = 0;
  logic       auto_pop = 1'b0;
  logic [7:0] popped_q[$];

  always #10 clk = ~clk;

  uart_rx_os16 #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (781_250),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  uart_rx_os16 #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (115200),
    .FIFO_DEPTH (DEPTH)
  ) u_slow (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_slow),
    .rx_data    (slow_rx_data),
    .rx_valid   (slow_rx_valid),
    .rx_ready   (1'b0),
    .rx_done    (slow_rx_done),
    .frame_err  (slow_frame_err),
    .overrun    (slow_overrun),
    .fifo_count (slow_fifo_count)
  );

  always @(negedge clk) begin
    if (rx_done)        done_cnt++;
    if (frame_err)      ferr_cnt++;
    if (slow_rx_done)   slow_done_cnt++;
    if (slow_frame_err) slow_ferr_cnt++;
    if (auto_pop && rx_valid && rx_ready) popped_q.push_back(rx_data);
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not reach the end, observed running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx = v;
    else          rx_slow = v;
  endtask

  task automatic send_raw(input int sel, input logic [7:0] b, input logic stop, input int bclk);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(sel, f[i]);
      repeat (bclk) @(posedge clk);
      #1;
    end
    drive(sel, 1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model rule: good stop -> byte stored if room, else overrun; bad stop -> frame error.
  task automatic send(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr++;
    else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
      exp_done++;
    end else exp_ovr = 1'b1;
    send_raw(0, b, stop, FAST_BCLK);
  endtask

  task automatic pop_expect(input string tag);
    logic [7:0] e;
    @(negedge clk);
    check({tag, "_valid"}, rx_valid, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rx_data, e);
    end else begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_model: observed pop expected no data", tag);
    end
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [9:0] f;
    logic [7:0] b;
    int         gap;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data",   rx_data,    8'h00);
    check("rst_valid",  rx_valid,   1'b0);
    check("rst_done",   rx_done,    1'b0);
    check("rst_ferr",   frame_err,  1'b0);
    check("rst_ovr",    overrun,    1'b0);
    check("rst_count",  fifo_count, 3'd0);
    rst = 1'b0;
    idle(20);

    // Single byte
    send(8'hA5, 1'b1);
    idle(4);
    check("a5_done", done_cnt, exp_done);
    check("a5_ferr", ferr_cnt, exp_ferr);
    check("a5_count", fifo_count, exp_q.size());
    pop_expect("a5");
    idle(FAST_BCLK);

    // Back-to-back with consumer always ready
    rx_ready = 1'b1;
    auto_pop = 1'b1;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    idle(2 * FAST_BCLK);
    auto_pop = 1'b0;
    rx_ready = 1'b0;
    check("b2b_done", done_cnt, exp_done);
    check("b2b_npop", popped_q.size(), exp_q.size());
    while (exp_q.size() > 0 && popped_q.size() > 0)
      check("b2b_order", popped_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    check("b2b_count", fifo_count, 3'd0);

    // Stop bit low, then a good copy of the same byte
    send(8'h3C, 1'b0);
    idle(2 * FAST_BCLK);
    check("ferr_cnt", ferr_cnt, exp_ferr);
    check("ferr_done", done_cnt, exp_done);
    check("ferr_count", fifo_count, 3'd0);
    send(8'h3C, 1'b1);
    idle(4);
    check("after_ferr_done", done_cnt, exp_done);
    pop_expect("after_ferr");

    // Short low glitch: 4 sample ticks
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    idle(3 * FAST_BCLK);
    check("glitch_done", done_cnt, exp_done);
    check("glitch_ferr", ferr_cnt, exp_ferr);
    check("glitch_count", fifo_count, 3'd0);

    // Break: line held low for many frame times -> single frame error
    exp_ferr++;
    rx = 1'b0;
    repeat (30 * FAST_BCLK) @(posedge clk);
    #1;
    idle(2 * FAST_BCLK);
    check("break_ferr", ferr_cnt, exp_ferr);
    check("break_done", done_cnt, exp_done);

    // Randomized bytes, popped one by one
    for (int i = 0; i < 8; i++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(1, 80);
      send(b, 1'b1);
      idle(2);
      check("rnd_count", fifo_count, exp_q.size());
      pop_expect("rnd");
      idle(gap);
    end
    check("rnd_done", done_cnt, exp_done);

    // Overrun: five bytes into a depth-4 FIFO with no consumer
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    idle(FAST_BCLK);
    check("ovr_count", fifo_count, exp_q.size());
    check("ovr_flag", overrun, exp_ovr);
    check("ovr_done", done_cnt, exp_done);
    for (int i = 0; i < 4; i++) pop_expect("ovr_pop");
    check("ovr_empty", fifo_count, 3'd0);
    check("ovr_sticky", overrun, exp_ovr);

    // Reset during data bit 3 of 8'hC3
    send(8'h99, 1'b1);  // leave a byte in the FIFO so the reset clearing it is visible
    idle(4);
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = f[i];
      repeat (FAST_BCLK) @(posedge clk);
      #1;
    end
    rx = f[4];
    repeat (FAST_BCLK / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_count", fifo_count, 3'd0);
    check("mid_rst_data",  rx_data, 8'h00);
    check("mid_rst_ovr",   overrun, exp_ovr);
    check("mid_rst_done",  rx_done, 1'b0);
    check("mid_rst_ferr",  frame_err, 1'b0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(FAST_BCLK);
    send(8'h7E, 1'b1);
    idle(4);
    check("post_rst_done", done_cnt, exp_done);
    check("post_rst_ferr", ferr_cnt, exp_ferr);
    pop_expect("post_rst");

    // Slow instance: 115200 baud, one byte
    send_raw(1, 8'hA5, 1'b1, SLOW_BCLK);
    repeat (SLOW_BCLK) @(posedge clk);
    #1;
    check("slow_done",  slow_done_cnt, 1);
    check("slow_ferr",  slow_ferr_cnt, 0);
    check("slow_valid", slow_rx_valid, 1'b1);
    check("slow_data",  slow_rx_data, 8'hA5);
    check("slow_count", slow_fifo_count, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
